// File: rtl/gray_wptr_gen_bin2gray.sv
// Combinational binary-to-Gray encoder.
module bin2gray #(
    parameter int DATA_WIDTH = 4
) (
    input  logic [DATA_WIDTH-1:0] bin_i,
    output logic [DATA_WIDTH-1:0] gray_o
);

    assign gray_o = bin_i ^ (bin_i >> 1);

endmodule

// File: rtl/gray_wptr_gen.sv
// Async-FIFO write pointer: binary address, registered Gray pointer and full flag.
// Optional level output is enabled with `define GRAY_WPTR_LEVEL_EN.
module gray_wptr_gen #(
    parameter int ADDR_WIDTH = 4
) (
    input  logic                  clk_i,
    input  logic                  rst_n_i,
    input  logic                  flush_i,
    input  logic                  inc_i,
    input  logic [ADDR_WIDTH:0]   rptr_gray_i,
    output logic                  accept_o,
    output logic [ADDR_WIDTH-1:0] waddr_o,
    output logic [ADDR_WIDTH:0]   wptr_gray_o,
`ifdef GRAY_WPTR_LEVEL_EN
    output logic [ADDR_WIDTH:0]   level_o,
`endif
    output logic                  full_o
);

    localparam int PTR_WIDTH = ADDR_WIDTH + 1;

    logic [PTR_WIDTH-1:0] wbin_q, wbin_d, wbin_next;
    logic [PTR_WIDTH-1:0] wgray_q, wgray_d, wgray_next;
    logic                 full_q, full_d;
    logic [PTR_WIDTH-1:0] rptr_full_cmp;

    assign accept_o  = inc_i & ~full_q & ~flush_i;
    assign wbin_next = wbin_q + PTR_WIDTH'(accept_o);

    bin2gray #(
        .DATA_WIDTH(PTR_WIDTH)
    ) u_bin2gray (
        .bin_i  (wbin_next),
        .gray_o (wgray_next)
    );

    // Full when the write pointer is one lap ahead: top two Gray bits inverted.
    assign rptr_full_cmp = {~rptr_gray_i[ADDR_WIDTH:ADDR_WIDTH-1],
                            rptr_gray_i[ADDR_WIDTH-2:0]};

    always_comb begin
        wbin_d  = wbin_next;
        wgray_d = wgray_next;
        full_d  = (wgray_next == rptr_full_cmp);
        if (flush_i) begin
            wbin_d  = '0;
            wgray_d = '0;
            full_d  = 1'b0;
        end
    end

    always_ff @(posedge clk_i or negedge rst_n_i) begin
        if (!rst_n_i) begin
            wbin_q  <= '0;
            wgray_q <= '0;
            full_q  <= 1'b0;
        end else begin
            wbin_q  <= wbin_d;
            wgray_q <= wgray_d;
            full_q  <= full_d;
        end
    end

    assign waddr_o     = wbin_q[ADDR_WIDTH-1:0];
    assign wptr_gray_o = wgray_q;
    assign full_o      = full_q;

`ifdef GRAY_WPTR_LEVEL_EN
    logic [PTR_WIDTH-1:0] rbin;
    logic [PTR_WIDTH-1:0] level_q, level_d;

    always_comb begin
        rbin[PTR_WIDTH-1] = rptr_gray_i[PTR_WIDTH-1];
        for (int i = PTR_WIDTH - 2; i >= 0; i--) begin
            rbin[i] = rbin[i+1] ^ rptr_gray_i[i];
        end
    end

    always_comb begin
        level_d = wbin_next - rbin;
        if (flush_i) begin
            level_d = '0;
        end
    end

    always_ff @(posedge clk_i or negedge rst_n_i) begin
        if (!rst_n_i) begin
            level_q <= '0;
        end else begin
            level_q <= level_d;
        end
    end

    assign level_o = level_q;
`endif

endmodule

// File: doc/gray_wptr_gen.md
Name: gray_wptr_gen

Overview:
- Write-side pointer generator for an asynchronous FIFO.
- Keeps a binary write pointer and exports a registered, glitch-free Gray-coded copy for crossing into the read clock domain.
- Generates the full flag by comparing its own Gray pointer with the read pointer. The read pointer arrives already synchronized and Gray-coded.
- Sits between the FIFO write port and the RAM write address. It is the encode/produce end of the Gray pointer crossing.

Parameters:
- ADDR_WIDTH, 4, FIFO address width; depth = 2**ADDR_WIDTH; pointer width = ADDR_WIDTH+1; legal range ADDR_WIDTH >= 2.

Ports:
- clk_i  input  1  write-domain clock
- rst_n_i  input  1  asynchronous active-low reset
- flush_i  input  1  synchronous clear of the write pointer
- inc_i  input  1  write request
- rptr_gray_i  input  ADDR_WIDTH+1  read pointer, Gray-coded, already synchronized into clk_i domain
- accept_o  output  1  write accepted this cycle (combinational: inc_i & ~full_o & ~flush_i); drives the RAM write enable
- waddr_o  output  ADDR_WIDTH  RAM write address (low bits of the binary pointer)
- wptr_gray_o  output  ADDR_WIDTH+1  registered Gray write pointer, sent to the read-domain synchronizer
- full_o  output  1  FIFO full, registered

Behaviour:
- Reset (rst_n_i low, asynchronous): binary pointer = 0, wptr_gray_o = 0, full_o = 0, waddr_o = 0.
- Registered state: wbin [ADDR_WIDTH:0], wgray [ADDR_WIDTH:0], full. No other state.
- Next-state computation:
  - wbin_next = wbin + accept_o, modulo 2**(ADDR_WIDTH+1).
  - wgray_next = wbin_next ^ (wbin_next >> 1).
  - full_next = (wgray_next == {~rptr_gray_i[ADDR_WIDTH:ADDR_WIDTH-1], rptr_gray_i[ADDR_WIDTH-2:0]}).
- All three registers update on every clk_i rising edge.
- wptr_gray_o comes straight from a flop, with no logic after it.
- Latency:
  - An accepted write updates waddr_o and wptr_gray_o on the next edge.
  - full_o reflects that write on the same edge.
- Full deassertion is pessimistic. A change on rptr_gray_i clears full_o one cycle later. A write is never accepted while full_o = 1.
- Gray invariant: consecutive wptr_gray_o values differ in exactly one bit. This includes the wrap from wbin = 2**(ADDR_WIDTH+1)-1 to wbin = 0 (e.g. Gray 100 -> 000 for ADDR_WIDTH = 2).
- flush_i:
  - Clears wbin, wgray and full to 0 on the next edge.
  - Overrides inc_i; accept_o = 0 during flush.
  - The read side must be flushed by the system. This block does not coordinate that.
- inc_i while full_o = 1: write is dropped, accept_o = 0, pointer holds.
- inc_i and a read-pointer change in the same cycle: the write is decided on the current full_o. full_next is computed from the new rptr_gray_i.
- rptr_gray_i is sampled only combinationally into full_next. No decode or checking of its single-bit-change property.

Optional Feature:
- Macro: GRAY_WPTR_LEVEL_EN.
- Defined:
  - Adds output level_o [ADDR_WIDTH:0], registered.
  - level_o = (wbin_next - rbin) mod 2**(ADDR_WIDTH+1), where rbin is the XOR-prefix decode of rptr_gray_i.
  - Reset and flush value is 0. Same 1-cycle latency as full_o.
  - Range 0..2**ADDR_WIDTH; level_o = 2**ADDR_WIDTH exactly when full_o = 1.
- Undefined: port absent, no decode logic.

Decomposition:
- No shared package types needed.
- Localparam PTR_WIDTH = ADDR_WIDTH+1 is kept inside the module.
- One sub-module: bin2gray, a combinational DATA_WIDTH-parameterized encoder (bin ^ bin >> 1), instantiated for wgray_next.
- The level decode is inline under the macro.

Test Plan (ADDR_WIDTH = 2, depth 4):
- Reset, then hold rptr_gray_i = 0, inc_i = 0 -> waddr_o = 0, wptr_gray_o = 000, full_o = 0, accept_o = 0.
- rptr_gray_i = 000, inc_i = 1 for 5 cycles:
  - wptr_gray_o steps 001, 011, 010, 110; full_o = 1 after the 4th accept.
  - 5th cycle: accept_o = 0, pointer holds at 110.
- While full, rptr_gray_i 000 -> 001 -> full_o = 0 on the following edge; the next inc_i is accepted and wptr_gray_o becomes 111.
- Wrap: 8 accepts with rptr_gray_i kept 2 behind -> Gray sequence ends 101, 100, 000; exactly one bit changes per step; full_o never asserts.
- flush_i = 1 together with inc_i = 1 at wptr_gray_o = 010 -> accept_o = 0; next edge wbin = 0, wptr_gray_o = 000, full_o = 0.
- With GRAY_WPTR_LEVEL_EN: 3 accepts, then rptr_gray_i = 001 -> level_o = 2; fill to full -> level_o = 4 coincident with full_o = 1.
